// File: rtl/mm_engine_pkg.sv
// Shared types and helpers for the matrix-multiply engine blocks.
// The writeback buffer uses them here, and the processor array shares the accumulator width.
package mm_engine_pkg;

    localparam int DEFAULT_ACCUM_WIDTH = 32;

    typedef enum logic [1:0] {
        WB_IDLE    = 2'd0,
        WB_COLLECT = 2'd1,
        WB_DRAIN   = 2'd2
    } wb_state_e;

    // Number of memory write beats needed to move one tile row.
    function automatic int wb_beats_per_row(input int n, input int parallel);
        return n / parallel;
    endfunction

    // Index width for a counter over 'count' positions; never narrower than 1 bit.
    function automatic int wb_index_bits(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/result_writeback_buffer_address_gen.sv
// Walks the drain order of a buffered tile: row r, chunk c, and the running row base address.
// The next row's base address is built by adding the stride, not by multiplying.
module writeback_address_gen
    import mm_engine_pkg::*;
#(
    parameter int N = 4,
    parameter int PARALLEL_DATA_STREAMING_SIZE = 4,
    parameter int MEMORY_ADDRESS_BITS = 64,
    parameter int COUNTER_BITS = 13,
    localparam int BEATS_PER_ROW = wb_beats_per_row(N, PARALLEL_DATA_STREAMING_SIZE),
    localparam int ROW_BITS = wb_index_bits(N),
    localparam int CHUNK_BITS = wb_index_bits(BEATS_PER_ROW)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic                           advance,
    input  logic [MEMORY_ADDRESS_BITS-1:0] base,
    input  logic [COUNTER_BITS-1:0]        stride,
    output logic [MEMORY_ADDRESS_BITS-1:0] address,
    output logic [ROW_BITS-1:0]            row_index,
    output logic [CHUNK_BITS-1:0]          chunk_index,
    output logic                           last_chunk_of_row,
    output logic                           last_beat_of_tile
);

    logic [MEMORY_ADDRESS_BITS-1:0] row_base;
    logic [MEMORY_ADDRESS_BITS-1:0] stride_ext;
    logic [MEMORY_ADDRESS_BITS-1:0] chunk_offset;

    assign stride_ext   = MEMORY_ADDRESS_BITS'(stride);
    assign chunk_offset = MEMORY_ADDRESS_BITS'(chunk_index)
                        * MEMORY_ADDRESS_BITS'(PARALLEL_DATA_STREAMING_SIZE);
    assign address      = row_base + chunk_offset;

    assign last_chunk_of_row = (chunk_index == CHUNK_BITS'(BEATS_PER_ROW - 1));
    assign last_beat_of_tile = last_chunk_of_row && (row_index == ROW_BITS'(N - 1));

    // Counters hold while a beat is stalled, which keeps address and data stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_base    <= '0;
            row_index   <= '0;
            chunk_index <= '0;
        end else if (load) begin
            row_base    <= base;
            row_index   <= '0;
            chunk_index <= '0;
        end else if (advance) begin
            if (last_chunk_of_row) begin
                chunk_index <= '0;
                row_base    <= row_base + stride_ext;
                if (last_beat_of_tile) begin
                    row_index <= '0;
                end else begin
                    row_index <= row_index + ROW_BITS'(1);
                end
            end else begin
                chunk_index <= chunk_index + CHUNK_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/result_writeback_buffer.sv
// Captures one N x N result tile from the processor array, one row at a time.
// It then writes the tile to memory in beats at a controller-supplied base address and row stride.
module result_writeback_buffer
    import mm_engine_pkg::*;
#(
    parameter int ACCUM_WIDTH = DEFAULT_ACCUM_WIDTH,
    parameter int N = 4,
    parameter int MEMORY_ADDRESS_BITS = 64,
    parameter int PARALLEL_DATA_STREAMING_SIZE = 4,
    parameter int MAX_MATRIX_LENGTH = 4096,
    parameter int COUNTER_BITS = $clog2(MAX_MATRIX_LENGTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           instruction_valid,
    output logic                           instruction_ready,
    input  logic [MEMORY_ADDRESS_BITS-1:0] address_input,
    input  logic [COUNTER_BITS-1:0]        stride_input,
    input  logic                           processor_output_valid,
    output logic                           processor_output_ready,
    input  logic [ACCUM_WIDTH-1:0]         processor_output_data [N-1:0],
    input  logic                           processor_output_last,
    output logic                           memory_write_valid,
    input  logic                           memory_write_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0] memory_write_address,
    output logic [ACCUM_WIDTH-1:0]         memory_write_data [PARALLEL_DATA_STREAMING_SIZE-1:0],
    output logic                           tile_done,
    output logic                           protocol_error
);

    localparam int BEATS_PER_ROW = wb_beats_per_row(N, PARALLEL_DATA_STREAMING_SIZE);
    localparam int ROW_BITS      = wb_index_bits(N);
    localparam int COL_BITS      = wb_index_bits(N);
    localparam int CHUNK_BITS    = wb_index_bits(BEATS_PER_ROW);

    if ((PARALLEL_DATA_STREAMING_SIZE < 1) || ((N % PARALLEL_DATA_STREAMING_SIZE) != 0)) begin : g_bad_parallel
        $error("N must be an integer multiple of PARALLEL_DATA_STREAMING_SIZE");
    end

    wb_state_e                      state;
    logic [MEMORY_ADDRESS_BITS-1:0] base_reg;
    logic [COUNTER_BITS-1:0]        stride_reg;
    logic [ROW_BITS-1:0]            collect_row;
    logic [ACCUM_WIDTH-1:0]         buffer [N][N];

    logic                           instruction_accept;
    logic                           row_accept;
    logic                           final_row;
    logic                           beat_accept;
    logic [ROW_BITS-1:0]            drain_row;
    logic [CHUNK_BITS-1:0]          drain_chunk;
    logic                           last_chunk_of_row;
    logic                           last_beat_of_tile;
    logic [COL_BITS-1:0]            col;

    assign instruction_accept = instruction_valid && instruction_ready;
    assign row_accept         = processor_output_valid && processor_output_ready;
    assign final_row          = (collect_row == ROW_BITS'(N - 1));
    assign beat_accept        = memory_write_valid && memory_write_ready;
    assign tile_done          = beat_accept && last_chunk_of_row && last_beat_of_tile;

    writeback_address_gen #(
        .N                            (N),
        .PARALLEL_DATA_STREAMING_SIZE (PARALLEL_DATA_STREAMING_SIZE),
        .MEMORY_ADDRESS_BITS          (MEMORY_ADDRESS_BITS),
        .COUNTER_BITS                 (COUNTER_BITS)
    ) address_gen (
        .clk               (clk),
        .reset             (reset),
        .load              (row_accept && final_row),
        .advance           (beat_accept),
        .base              (base_reg),
        .stride            (stride_reg),
        .address           (memory_write_address),
        .row_index         (drain_row),
        .chunk_index       (drain_chunk),
        .last_chunk_of_row (last_chunk_of_row),
        .last_beat_of_tile (last_beat_of_tile)
    );

    // Buffer storage has no reset: a tile is always fully rewritten before it is drained.
    always_ff @(posedge clk) begin
        if (row_accept) begin
            for (int j = 0; j < N; j++) begin
                buffer[collect_row][j] <= processor_output_data[j];
            end
        end
    end

    always_comb begin
        col = '0;
        for (int k = 0; k < PARALLEL_DATA_STREAMING_SIZE; k++) begin
            col = COL_BITS'(int'(drain_chunk) * PARALLEL_DATA_STREAMING_SIZE + k);
            memory_write_data[k] = buffer[drain_row][col];
        end
    end

    // Collection always takes exactly N rows; a misplaced 'last' only raises the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= WB_IDLE;
            base_reg               <= '0;
            stride_reg             <= '0;
            collect_row            <= '0;
            instruction_ready      <= 1'b1;
            processor_output_ready <= 1'b0;
            memory_write_valid     <= 1'b0;
            protocol_error         <= 1'b0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (instruction_accept) begin
                        base_reg               <= address_input;
                        stride_reg             <= stride_input;
                        collect_row            <= '0;
                        instruction_ready      <= 1'b0;
                        processor_output_ready <= 1'b1;
                        state                  <= WB_COLLECT;
                    end
                end
                WB_COLLECT: begin
                    if (row_accept) begin
                        if (processor_output_last != final_row) begin
                            protocol_error <= 1'b1;
                        end
                        if (final_row) begin
                            collect_row            <= '0;
                            processor_output_ready <= 1'b0;
                            memory_write_valid     <= 1'b1;
                            state                  <= WB_DRAIN;
                        end else begin
                            collect_row <= collect_row + ROW_BITS'(1);
                        end
                    end
                end
                WB_DRAIN: begin
                    if (tile_done) begin
                        memory_write_valid <= 1'b0;
                        instruction_ready  <= 1'b1;
                        state              <= WB_IDLE;
                    end
                end
                default: begin
                    instruction_ready      <= 1'b1;
                    processor_output_ready <= 1'b0;
                    memory_write_valid     <= 1'b0;
                    state                  <= WB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_writeback_buffer.sv
// Directed bench for result_writeback_buffer: a default instance (4 values per beat) and a 2-values-per-beat instance.
// Expected addresses and data come from the tile geometry computed by the bench.
module tb_result_writeback_buffer;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int MAB = 64;
    localparam int CB  = 13;

    logic clk = 1'b0;
    logic reset;

    logic           instruction_valid;
    logic           use_b;
    logic [MAB-1:0] address_input;
    logic [CB-1:0]  stride_input;
    logic           proc_valid;
    logic           proc_last;
    logic [AW-1:0]  proc_data [N-1:0];
    logic           mem_ready;

    logic           a_instr_ready, a_proc_ready, a_mwv, a_done, a_err;
    logic [MAB-1:0] a_addr;
    logic [AW-1:0]  a_data [3:0];
    logic           b_instr_ready, b_proc_ready, b_mwv, b_done, b_err;
    logic [MAB-1:0] b_addr;
    logic [AW-1:0]  b_data [1:0];

    logic           obs_instr_ready, obs_proc_ready, obs_mwv, obs_done, obs_err;
    logic [MAB-1:0] obs_addr;
    logic [AW-1:0]  obs_data [4];

    int checks   = 0;
    int failures = 0;
    int cyc;

    always #5 clk = ~clk;

    result_writeback_buffer dut_a (
        .clk                    (clk),
        .reset                  (reset),
        .instruction_valid      (instruction_valid && !use_b),
        .instruction_ready      (a_instr_ready),
        .address_input          (address_input),
        .stride_input           (stride_input),
        .processor_output_valid (proc_valid),
        .processor_output_ready (a_proc_ready),
        .processor_output_data  (proc_data),
        .processor_output_last  (proc_last),
        .memory_write_valid     (a_mwv),
        .memory_write_ready     (mem_ready),
        .memory_write_address   (a_addr),
        .memory_write_data      (a_data),
        .tile_done              (a_done),
        .protocol_error         (a_err)
    );

    result_writeback_buffer #(.PARALLEL_DATA_STREAMING_SIZE(2)) dut_b (
        .clk                    (clk),
        .reset                  (reset),
        .instruction_valid      (instruction_valid && use_b),
        .instruction_ready      (b_instr_ready),
        .address_input          (address_input),
        .stride_input           (stride_input),
        .processor_output_valid (proc_valid),
        .processor_output_ready (b_proc_ready),
        .processor_output_data  (proc_data),
        .processor_output_last  (proc_last),
        .memory_write_valid     (b_mwv),
        .memory_write_ready     (mem_ready),
        .memory_write_address   (b_addr),
        .memory_write_data      (b_data),
        .tile_done              (b_done),
        .protocol_error         (b_err)
    );

    // The idle instance never receives an instruction, so sharing row and memory inputs is harmless.
    always_comb begin
        obs_instr_ready = use_b ? b_instr_ready : a_instr_ready;
        obs_proc_ready  = use_b ? b_proc_ready  : a_proc_ready;
        obs_mwv         = use_b ? b_mwv         : a_mwv;
        obs_done        = use_b ? b_done        : a_done;
        obs_err         = use_b ? b_err         : a_err;
        obs_addr        = use_b ? b_addr        : a_addr;
        obs_data[0]     = use_b ? b_data[0]     : a_data[0];
        obs_data[1]     = use_b ? b_data[1]     : a_data[1];
        obs_data[2]     = use_b ? '0            : a_data[2];
        obs_data[3]     = use_b ? '0            : a_data[3];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one tile on the selected instance; abort_beat >= 0 pulses reset while that beat is presented.
    task automatic applyStimulus(input logic [63:0] base, input logic [CB-1:0] stride, input int p,
                                 input int seed, input int stall_pct, input int bad_last_row,
                                 input bit hold_instr, input int abort_beat, output int cycles);
        int row, beat, budget, total, bpr, r, c;
        bit gap;
        logic [63:0] exp_addr;
        cycles = 0;
        address_input     = base;
        stride_input      = stride;
        instruction_valid = 1'b1;
        checkOutput("instr_ready_idle", obs_instr_ready, 1);
        tick();
        cycles++;
        if (hold_instr) begin
            address_input = 64'hDEAD_BEEF_0000;
            stride_input  = 13'd3;
        end else begin
            instruction_valid = 1'b0;
        end
        row = 0;
        budget = 0;
        while (row < N && budget < 100) begin
            checkOutput("row_ready_collect", obs_proc_ready, 1);
            checkOutput("instr_ready_collect", obs_instr_ready, 0);
            checkOutput("wvalid_collect", obs_mwv, 0);
            gap = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
            proc_valid = !gap;
            for (int j = 0; j < N; j++) proc_data[j] = AW'(seed + 10 * row + j);
            proc_last = (row == N - 1) || (row == bad_last_row);
            tick();
            cycles++;
            budget++;
            if (!gap) row++;
        end
        proc_valid = 1'b0;
        proc_last = 1'b0;
        instruction_valid = 1'b0;
        if (row < N) begin
            checkOutput("collect_timeout", 64'(row), 64'(N));
            return;
        end
        bpr = N / p;
        total = N * bpr;
        beat = 0;
        budget = 0;
        while (beat < total && budget < 200) begin
            r = beat / bpr;
            c = beat % bpr;
            exp_addr = base + 64'(r) * 64'(stride) + 64'(c * p);
            checkOutput("wvalid_drain", obs_mwv, 1);
            checkOutput("waddr", obs_addr, exp_addr);
            for (int k = 0; k < p; k++)
                checkOutput($sformatf("wdata_r%0d_c%0d_k%0d", r, c, k), 64'(obs_data[k]), 64'(seed + 10 * r + c * p + k));
            checkOutput("instr_ready_drain", obs_instr_ready, 0);
            checkOutput("row_ready_drain", obs_proc_ready, 0);
            if (beat == abort_beat) begin
                mem_ready = 1'b0;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                checkOutput("abort_wvalid", obs_mwv, 0);
                checkOutput("abort_instr_ready", obs_instr_ready, 1);
                checkOutput("abort_tile_done", obs_done, 0);
                checkOutput("abort_error_cleared", obs_err, 0);
                return;
            end
            gap = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
            mem_ready = !gap;
            #1;
            checkOutput("tile_done", obs_done, (!gap && beat == total - 1) ? 1 : 0);
            tick();
            cycles++;
            budget++;
            if (!gap) beat++;
        end
        mem_ready = 1'b0;
        if (beat < total) begin
            checkOutput("drain_timeout", 64'(beat), 64'(total));
            return;
        end
        checkOutput("wvalid_after", obs_mwv, 0);
        checkOutput("tile_done_after", obs_done, 0);
        checkOutput("instr_ready_after", obs_instr_ready, 1);
    endtask

    initial begin
        reset = 1'b1;
        use_b = 1'b0;
        instruction_valid = 1'b0;
        address_input = '0;
        stride_input = '0;
        proc_valid = 1'b0;
        proc_last = 1'b0;
        mem_ready = 1'b0;
        for (int j = 0; j < N; j++) proc_data[j] = '0;
        tick();
        tick();
        checkOutput("reset_instr_ready", a_instr_ready, 1);
        checkOutput("reset_row_ready", a_proc_ready, 0);
        checkOutput("reset_wvalid", a_mwv, 0);
        checkOutput("reset_tile_done", a_done, 0);
        checkOutput("reset_error", a_err, 0);
        checkOutput("reset_b_instr_ready", b_instr_ready, 1);
        reset = 1'b0;
        tick();

        $display("[TB] default tile, no backpressure");
        applyStimulus(64'h100, 13'd16, 4, 0, 0, -1, 1'b0, -1, cyc);
        checkOutput("latency_default", 64'(cyc), 9);
        checkOutput("error_default", a_err, 0);

        $display("[TB] two values per beat");
        use_b = 1'b1;
        applyStimulus(64'h0, 13'd8, 2, 100, 0, -1, 1'b0, -1, cyc);
        checkOutput("latency_p2", 64'(cyc), 13);
        $display("[TB] two values per beat, stride 0 with stalls");
        applyStimulus(64'h40, 13'd0, 2, 150, 30, -1, 1'b0, -1, cyc);
        checkOutput("error_p2", b_err, 0);
        use_b = 1'b0;

        $display("[TB] random row gaps and write backpressure");
        applyStimulus(64'hFFFF_FFFF_FFFF_FFE0, 13'd32, 4, 200, 40, -1, 1'b0, -1, cyc);
        applyStimulus(64'h2000, 13'd4096, 4, 250, 50, -1, 1'b0, -1, cyc);

        $display("[TB] instruction held during collect");
        applyStimulus(64'h4000, 13'd64, 4, 300, 0, -1, 1'b1, -1, cyc);
        checkOutput("latency_hold", 64'(cyc), 9);

        $display("[TB] early last on row 1");
        applyStimulus(64'h500, 13'd16, 4, 400, 0, 1, 1'b0, -1, cyc);
        checkOutput("error_set", a_err, 1);
        applyStimulus(64'h580, 13'd16, 4, 450, 0, -1, 1'b0, -1, cyc);
        checkOutput("error_sticky", a_err, 1);

        $display("[TB] reset during second drain beat");
        applyStimulus(64'h600, 13'd16, 4, 500, 0, -1, 1'b0, 1, cyc);
        applyStimulus(64'h700, 13'd16, 4, 600, 0, -1, 1'b0, -1, cyc);
        checkOutput("latency_after_reset", 64'(cyc), 9);
        checkOutput("error_after_reset", a_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
